// File: rtl/psum_mem_arbiter_if.sv
// Bus bundle between the two core controllers, the pmem SRAM macro and the arbiter.
// master: the controller/SRAM side of the bundle; slave: the arbiter.
interface psum_mem_arbiter_if #(
  parameter int unsigned dw = 160,
  parameter int unsigned aw = 4,
  parameter int unsigned lw = 5
);
  // core0 request channel
  logic          req0;
  logic          wr0;
  logic [aw-1:0] addr0;
  logic [lw-1:0] len0;
  logic [dw-1:0] wdata0;
  logic          gnt0;
  logic          rvalid0;
  // core1 request channel
  logic          req1;
  logic          wr1;
  logic [aw-1:0] addr1;
  logic [lw-1:0] len1;
  logic [dw-1:0] wdata1;
  logic          gnt1;
  logic          rvalid1;
  // shared read data and SRAM pins
  logic [dw-1:0] rdata;
  logic          mem_cen;
  logic          mem_wen;
  logic [aw-1:0] mem_a;
  logic [dw-1:0] mem_d;
  logic [dw-1:0] mem_q;
  logic          busy;

  modport master (
    output req0, wr0, addr0, len0, wdata0,
    output req1, wr1, addr1, len1, wdata1,
    output mem_q,
    input  gnt0, rvalid0, gnt1, rvalid1, rdata,
    input  mem_cen, mem_wen, mem_a, mem_d, busy
  );

  modport slave (
    input  req0, wr0, addr0, len0, wdata0,
    input  req1, wr1, addr1, len1, wdata1,
    input  mem_q,
    output gnt0, rvalid0, gnt1, rvalid1, rdata,
    output mem_cen, mem_wen, mem_a, mem_d, busy
  );
endinterface

// File: rtl/psum_mem_arbiter.sv
// Round-robin burst arbiter sharing the single-port psum SRAM between core0 and core1.
// A granted burst is atomic: it runs its latched length, then returns through IDLE.
module psum_mem_arbiter #(
  parameter int unsigned dw = 160,
  parameter int unsigned aw = 4,
  parameter int unsigned lw = 5
) (
  input logic                  clk,
  input logic                  reset,
  psum_mem_arbiter_if.slave    bus
);

  localparam int unsigned Depth = 2 ** aw;

  typedef logic [aw:0] len_t;
  typedef enum logic [1:0] {StIdle, StBurst0, StBurst1} state_e;

  state_e        state_q, state_d;
  logic          ptr_q, ptr_d;      // 0: core0 wins a tie, 1: core1 wins
  logic          arm_q;             // holds off arbitration for the first edge after reset
  len_t          cnt_q, cnt_d;
  len_t          len_q, len_d;
  logic [aw-1:0] addr_q, addr_d;
  logic          wr_q, wr_d;
  logic          rvalid0_q, rvalid0_d;
  logic          rvalid1_q, rvalid1_d;
  logic          grant0, grant1;
  logic          in_burst;

  // len = 0 means one beat; anything beyond the memory depth saturates at the depth.
  function automatic len_t eff_len(input logic [lw-1:0] len);
    int unsigned l;
    l = 32'(len);
    if (l == 0) begin
      l = 1;
    end else if (l > Depth) begin
      l = Depth;
    end
    return len_t'(l);
  endfunction

  // Arbitration in IDLE, beat counting in a burst, read-beat strobe for the next cycle.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    addr_d    = addr_q;
    wr_d      = wr_q;
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;
    grant0    = 1'b0;
    grant1    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (arm_q) begin
          grant0 = bus.req0 && (!bus.req1 || !ptr_q);
          grant1 = bus.req1 && (!bus.req0 || ptr_q);
          // The pointer only moves when both sides contend.
          if (bus.req0 && bus.req1) begin
            ptr_d = grant0;
          end
          if (grant0) begin
            state_d = StBurst0;
            wr_d    = bus.wr0;
            addr_d  = bus.addr0;
            len_d   = eff_len(bus.len0);
            cnt_d   = '0;
          end else if (grant1) begin
            state_d = StBurst1;
            wr_d    = bus.wr1;
            addr_d  = bus.addr1;
            len_d   = eff_len(bus.len1);
            cnt_d   = '0;
          end
        end
      end
      StBurst0, StBurst1: begin
        rvalid0_d = (state_q == StBurst0) && !wr_q;
        rvalid1_d = (state_q == StBurst1) && !wr_q;
        cnt_d     = cnt_q + len_t'(1);
        if (cnt_q == len_q - len_t'(1)) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, pointer, latched burst parameters and read strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      ptr_q     <= 1'b0;
      arm_q     <= 1'b0;
      cnt_q     <= '0;
      len_q     <= '0;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      arm_q     <= 1'b1;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end

  assign in_burst = (state_q != StIdle);

  // SRAM pins and grant outputs decode directly from the burst state.
  assign bus.gnt0    = (state_q == StBurst0);
  assign bus.gnt1    = (state_q == StBurst1);
  assign bus.busy    = in_burst;
  assign bus.mem_cen = !in_burst;
  assign bus.mem_wen = !(in_burst && wr_q);
  // Address wraps silently through the aw-bit add.
  assign bus.mem_a   = in_burst ? (addr_q + cnt_q[aw-1:0]) : '0;
  assign bus.mem_d   = (state_q == StBurst1) ? bus.wdata1 : bus.wdata0;
  assign bus.rdata   = bus.mem_q;
  assign bus.rvalid0 = rvalid0_q;
  assign bus.rvalid1 = rvalid1_q;

endmodule

// File: tb/tb_psum_mem_arbiter.sv
// Scoreboard bench for psum_mem_arbiter: stimulus pushes expected beats and read data,
// a negedge monitor pops and compares whenever the DUT grants or strobes rvalid.
module tb_psum_mem_arbiter;

  localparam int unsigned DW = 160;
  localparam int unsigned AW = 4;
  localparam int unsigned LW = 5;

  typedef struct {
    logic [AW-1:0] addr;
    logic          wen;
    logic [DW-1:0] data;
    bit            chk_d;
  } beat_t;

  logic clk;
  logic reset;

  psum_mem_arbiter_if #(.dw(DW), .aw(AW), .lw(LW)) bus ();

  psum_mem_arbiter #(.dw(DW), .aw(AW), .lw(LW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  beat_t         exp_beat0[$];
  beat_t         exp_beat1[$];
  logic [DW-1:0] exp_rd0[$];
  logic [DW-1:0] exp_rd1[$];
  int            order_q[$];
  logic [DW-1:0] ref_mem [16];
  logic [DW-1:0] sram [16];
  logic [DW-1:0] sram_q;
  int            tag_n = 1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM: one-cycle read latency.
  always @(posedge clk) begin
    if (!bus.mem_cen) begin
      if (!bus.mem_wen) sram[bus.mem_a] <= bus.mem_d;
      else sram_q <= sram[bus.mem_a];
    end
  end
  assign bus.mem_q = sram_q;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name);
    errors++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [DW-1:0] pat(input int side, input int tag, input int k);
    return {32'(side), 32'(tag), 32'(k), 64'hDEAD_BEEF_0123_4567};
  endfunction

  // Push the beats and read data a burst must produce; writes update the reference memory.
  task automatic push_exp(input int side, input bit wr, input int addr, input int len,
                          input int tag, output int l);
    beat_t e;
    l = (len == 0) ? 1 : ((len > 16) ? 16 : len);
    for (int k = 0; k < l; k++) begin
      e.addr  = AW'((addr + k) % 16);
      e.wen   = !wr;
      e.data  = pat(side, tag, k);
      e.chk_d = wr;
      if (wr) ref_mem[e.addr] = e.data;
      if (side == 0) begin
        exp_beat0.push_back(e);
        if (!wr) exp_rd0.push_back(ref_mem[e.addr]);
      end else begin
        exp_beat1.push_back(e);
        if (!wr) exp_rd1.push_back(ref_mem[e.addr]);
      end
    end
  endtask

  task automatic set_wdata(input int side, input logic [DW-1:0] d);
    if (side == 0) bus.wdata0 = d;
    else bus.wdata1 = d;
  endtask

  task automatic set_req(input int side, input bit r);
    if (side == 0) bus.req0 = r;
    else bus.req1 = r;
  endtask

  // Issue one burst, feed write data per grant cycle, and scramble the command mid-burst.
  task automatic run_burst(input int side, input bit wr, input int addr, input int len,
                           input int drop_after);
    int tag, l, k, cyc;
    bit g;
    tag = tag_n;
    tag_n++;
    push_exp(side, wr, addr, len, tag, l);
    if (side == 0) begin
      bus.wr0 = wr; bus.addr0 = AW'(addr); bus.len0 = LW'(len);
    end else begin
      bus.wr1 = wr; bus.addr1 = AW'(addr); bus.len1 = LW'(len);
    end
    set_wdata(side, pat(side, tag, 0));
    set_req(side, 1'b1);
    k = 0;
    cyc = 0;
    while (k < l && cyc < 200) begin
      @(negedge clk);
      g = (side == 0) ? bus.gnt0 : bus.gnt1;
      @(posedge clk);
      #1;
      cyc++;
      if (g) begin
        k++;
        set_wdata(side, pat(side, tag, k));
        if (k == 1) begin
          if (side == 0) begin
            bus.wr0 = !wr; bus.addr0 = AW'(addr + 7); bus.len0 = LW'(1);
          end else begin
            bus.wr1 = !wr; bus.addr1 = AW'(addr + 7); bus.len1 = LW'(1);
          end
        end
        if (k == drop_after) set_req(side, 1'b0);
      end
    end
    set_req(side, 1'b0);
    chk("burst beat count", DW'(k), DW'(l));
  endtask

  // Monitor: pops expected beats on grants and expected data on rvalid.
  bit prev_g0, prev_g1, prev_rd0, prev_rd1;
  always @(negedge clk) begin
    beat_t e;
    bit cur_rd0, cur_rd1;
    cur_rd0 = 1'b0;
    cur_rd1 = 1'b0;
    if (!reset) begin
      prev_g0 = 1'b0; prev_g1 = 1'b0; prev_rd0 = 1'b0; prev_rd1 = 1'b0;
    end else begin
      chk("gnt exclusive", DW'(bus.gnt0 & bus.gnt1), DW'(0));
      chk("rvalid exclusive", DW'(bus.rvalid0 & bus.rvalid1), DW'(0));
      chk("busy", DW'(bus.busy), DW'(bus.gnt0 | bus.gnt1));
      if (bus.gnt0) begin
        if (!prev_g0) begin
          order_q.push_back(0);
          chk("idle gap before gnt0", DW'(prev_g1), DW'(0));
        end
        checks++;
        if (exp_beat0.size() == 0) note_fail("gnt0 beat not expected");
        else begin
          e = exp_beat0.pop_front();
          chk("gnt0 mem_a", DW'(bus.mem_a), DW'(e.addr));
          chk("gnt0 mem_wen", DW'(bus.mem_wen), DW'(e.wen));
          if (e.chk_d) chk("gnt0 mem_d", bus.mem_d, e.data);
          cur_rd0 = e.wen;
        end
        chk("gnt0 mem_cen", DW'(bus.mem_cen), DW'(0));
      end
      if (bus.gnt1) begin
        if (!prev_g1) begin
          order_q.push_back(1);
          chk("idle gap before gnt1", DW'(prev_g0), DW'(0));
        end
        checks++;
        if (exp_beat1.size() == 0) note_fail("gnt1 beat not expected");
        else begin
          e = exp_beat1.pop_front();
          chk("gnt1 mem_a", DW'(bus.mem_a), DW'(e.addr));
          chk("gnt1 mem_wen", DW'(bus.mem_wen), DW'(e.wen));
          if (e.chk_d) chk("gnt1 mem_d", bus.mem_d, e.data);
          cur_rd1 = e.wen;
        end
        chk("gnt1 mem_cen", DW'(bus.mem_cen), DW'(0));
      end
      if (!bus.gnt0 && !bus.gnt1) begin
        chk("idle mem_cen", DW'(bus.mem_cen), DW'(1));
        chk("idle mem_wen", DW'(bus.mem_wen), DW'(1));
      end
      chk("rvalid0 timing", DW'(bus.rvalid0), DW'(prev_rd0));
      chk("rvalid1 timing", DW'(bus.rvalid1), DW'(prev_rd1));
      if (bus.rvalid0) begin
        checks++;
        if (exp_rd0.size() == 0) note_fail("rvalid0 not expected");
        else chk("rdata core0", bus.rdata, exp_rd0.pop_front());
      end
      if (bus.rvalid1) begin
        checks++;
        if (exp_rd1.size() == 0) note_fail("rvalid1 not expected");
        else chk("rdata core1", bus.rdata, exp_rd1.pop_front());
      end
      prev_g0  = bus.gnt0;
      prev_g1  = bus.gnt1;
      prev_rd0 = cur_rd0;
      prev_rd1 = cur_rd1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base, n, cyc, l;
    bus.req0 = 0; bus.wr0 = 0; bus.addr0 = '0; bus.len0 = '0; bus.wdata0 = '0;
    bus.req1 = 0; bus.wr1 = 0; bus.addr1 = '0; bus.len1 = '0; bus.wdata1 = '0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset gnt0", DW'(bus.gnt0), DW'(0));
    chk("reset gnt1", DW'(bus.gnt1), DW'(0));
    chk("reset rvalid", DW'({bus.rvalid0, bus.rvalid1}), DW'(0));
    chk("reset busy", DW'(bus.busy), DW'(0));
    chk("reset mem_cen", DW'(bus.mem_cen), DW'(1));
    chk("reset mem_wen", DW'(bus.mem_wen), DW'(1));
    chk("reset mem_a", DW'(bus.mem_a), DW'(0));
    reset = 1'b1;

    // Write burst 3..6, then idle.
    run_burst(0, 1'b1, 3, 4, 99);
    chk("busy after burst", DW'(bus.busy), DW'(0));
    // len 31 saturates to 16 beats covering every address.
    run_burst(1, 1'b1, 5, 31, 99);
    // Wrapping read 14,15,0,1.
    run_burst(1, 1'b0, 14, 4, 99);
    // len 0 is a single beat.
    run_burst(0, 1'b0, 9, 0, 99);
    run_burst(0, 1'b0, 3, 4, 99);

    // req0 dropped after 2 of 8 beats; req1 raised mid-burst waits for the idle cycle.
    base = order_q.size();
    fork
      run_burst(0, 1'b1, 8, 8, 2);
      begin
        repeat (5) @(posedge clk);
        #1;
        run_burst(1, 1'b0, 0, 2, 99);
      end
    join
    chk("mid-burst order 0", DW'(order_q[base]), DW'(0));
    chk("mid-burst order 1", DW'(order_q[base+1]), DW'(1));

    // Both sides contend continuously: strict alternation starting with core0.
    base = order_q.size();
    fork
      for (int i = 0; i < 3; i++) run_burst(0, 1'b1, i * 4, 3, 99);
      for (int j = 0; j < 3; j++) run_burst(1, 1'b1, 12 + 2 * j, 2, 99);
    join
    for (int i = 0; i < 6; i++) chk("alternation order", DW'(order_q[base+i]), DW'(i % 2));

    // Reset during beat 3 of a read burst.
    push_exp(0, 1'b0, 0, 8, tag_n, l);
    tag_n++;
    bus.wr0 = 0; bus.addr0 = '0; bus.len0 = LW'(l); bus.req0 = 1;
    n = 0;
    cyc = 0;
    while (n < 4 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus.gnt0) n++;
    end
    chk("beats before reset", DW'(n), DW'(4));
    #1;
    reset = 1'b0;
    bus.req0 = 0;
    #1;
    chk("abort gnt0", DW'(bus.gnt0), DW'(0));
    chk("abort rvalid0", DW'(bus.rvalid0), DW'(0));
    chk("abort mem_cen", DW'(bus.mem_cen), DW'(1));
    chk("abort busy", DW'(bus.busy), DW'(0));
    exp_beat0.delete();
    exp_rd0.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    // Pointer back at core0 after reset.
    base = order_q.size();
    fork
      run_burst(0, 1'b0, 0, 2, 99);
      run_burst(1, 1'b0, 4, 1, 99);
    join
    chk("post-reset order 0", DW'(order_q[base]), DW'(0));
    chk("post-reset order 1", DW'(order_q[base+1]), DW'(1));

    repeat (5) @(posedge clk);
    #1;
    chk("beats left core0", DW'(exp_beat0.size()), DW'(0));
    chk("beats left core1", DW'(exp_beat1.size()), DW'(0));
    chk("reads left core0", DW'(exp_rd0.size()), DW'(0));
    chk("reads left core1", DW'(exp_rd1.size()), DW'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
